// File: rtl/iperf_pkg.sv
// iperf_pkg: receiver FSM states and default packet geometry, shared by the iperf UDP sender and receiver
package iperf_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECK, RESPOND} state_t;
  localparam int DEF_HDR_WORDS = 41;
  localparam int DEF_PKT_WORDS = 1000;
endpackage

// File: rtl/iperf_udp_rx_if.sv
// iperf_udp_rx_if: sender word stream (in_valid/in_data/in_last/in_final) and report handshake (resp_*); master = sender/consumer side, slave = receiver
interface iperf_udp_rx_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_final;
  logic        resp_ready;
  logic        resp_valid;
  logic [31:0] resp_seq;
  logic [31:0] resp_pkt_count;
  modport master (output in_valid, in_data, in_last, in_final, resp_ready, input resp_valid, resp_seq, resp_pkt_count);
  modport slave (input in_valid, in_data, in_last, in_final, resp_ready, output resp_valid, resp_seq, resp_pkt_count);
endinterface

// File: rtl/iperf_sat_cnt.sv
// iperf_sat_cnt: W-bit counter that increments on inc and holds at all-ones (clk, rst_n async low, inc -> count)
module iperf_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/iperf_udp_rx.sv
// iperf_udp_rx: iperf UDP packet receiver checking length/sequence and reporting per session (clk, rst_n async low, rx slave bus, pkt_count, seq/len error counters, overrun, busy)
module iperf_udp_rx import iperf_pkg::*; #(
  parameter int HDR_WORDS = DEF_HDR_WORDS,
  parameter int PKT_WORDS = DEF_PKT_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iperf_udp_rx_if.slave        rx,
  output logic [31:0]          pkt_count,
  output logic [15:0]          seq_err_count,
  output logic [15:0]          len_err_count,
  output logic                 overrun,
  output logic                 busy
);
  state_t      state;
  logic [15:0] word_cnt;
  logic [31:0] pkt_seq;
  logic [31:0] exp_seq;
  logic        first;
  logic        final_l;
  logic [15:0] wc_inc;
  logic        len_ok;
  logic        chk;
  assign wc_inc = &word_cnt ? word_cnt : word_cnt + 16'd1;
  assign len_ok = word_cnt == 16'(PKT_WORDS);
  assign chk = state == CHECK;
  assign rx.resp_pkt_count = pkt_count;
  iperf_sat_cnt #(.W(16)) u_seq_err (
    .clk(clk), .rst_n(rst_n), .inc(chk && len_ok && !first && pkt_seq != exp_seq), .count(seq_err_count)
  );
  iperf_sat_cnt #(.W(16)) u_len_err (
    .clk(clk), .rst_n(rst_n), .inc(chk && !len_ok), .count(len_err_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      word_cnt      <= '0;
      pkt_seq       <= '0;
      exp_seq       <= '0;
      pkt_count     <= '0;
      rx.resp_seq   <= '0;
      rx.resp_valid <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
      first         <= 1'b1;
      final_l       <= 1'b0;
    end else begin
      if (rx.in_valid && (state == CHECK || state == RESPOND)) overrun <= 1'b1;
      case (state)
        IDLE: if (rx.in_valid) begin
          pkt_seq  <= rx.in_data;
          word_cnt <= 16'd1;
          final_l  <= rx.in_last && rx.in_final;
          state    <= rx.in_last ? CHECK : (HDR_WORDS <= 1 ? PAYLOAD : HEADER);
          busy     <= 1'b1;
        end
        HEADER, PAYLOAD: if (rx.in_valid) begin
          word_cnt <= wc_inc;
          if (rx.in_last) begin
            final_l <= rx.in_final;
            state   <= CHECK;
          end else if (state == HEADER && wc_inc == 16'(HDR_WORDS)) state <= PAYLOAD;
        end
        CHECK: begin
          if (len_ok) begin
            pkt_count   <= pkt_count + 32'd1;
            rx.resp_seq <= pkt_seq;
            exp_seq     <= pkt_seq + 32'd1;
            first       <= 1'b0;
          end
          state         <= final_l ? RESPOND : IDLE;
          rx.resp_valid <= final_l;
          busy          <= final_l;
        end
        RESPOND: if (rx.resp_ready) begin
          state         <= IDLE;
          rx.resp_valid <= 1'b0;
          busy          <= 1'b0;
          pkt_count     <= '0;
          first         <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iperf_udp_rx.sv
// tb_iperf_udp_rx: directed scoreboard bench for iperf_udp_rx
module tb_iperf_udp_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pkt_count;
  logic [15:0] seq_err_count, len_err_count;
  logic overrun, busy;
  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [31:0] m_pkt, m_exp, m_rseq;
  logic [15:0] m_seq, m_len;
  bit m_first;
  iperf_udp_rx_if rx ();
  iperf_udp_rx dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .pkt_count(pkt_count), .seq_err_count(seq_err_count),
    .len_err_count(len_err_count), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && rx.resp_valid && rx.resp_ready) begin
      if (q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
      else check("resp_report", {rx.resp_seq, rx.resp_pkt_count}, q.pop_front());
    end
  task automatic model_reset();
    m_pkt = 0; m_exp = 0; m_rseq = 0; m_seq = 0; m_len = 0; m_first = 1;
  endtask
  task automatic check_counters(input string tag);
    check({tag, "_pkt"}, 64'(pkt_count), 64'(m_pkt));
    check({tag, "_seqerr"}, 64'(seq_err_count), 64'(m_seq));
    check({tag, "_lenerr"}, 64'(len_err_count), 64'(m_len));
  endtask
  task automatic send(input logic [31:0] seq, input int n, input bit fin);
    if (n != 1000) m_len = (m_len == 16'hFFFF) ? m_len : m_len + 16'd1;
    else begin
      if (!m_first && seq != m_exp) m_seq = (m_seq == 16'hFFFF) ? m_seq : m_seq + 16'd1;
      m_pkt = m_pkt + 1; m_exp = seq + 1; m_rseq = seq; m_first = 0;
    end
    if (fin) q.push_back({m_rseq, m_pkt});
    for (int i = 0; i < n; i++) begin
      rx.in_valid = 1'b1;
      rx.in_data  = (i == 0) ? seq : $urandom;
      rx.in_last  = (i == n - 1);
      rx.in_final = (i == n - 1) ? fin : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rx.in_valid = 1'b0; rx.in_last = 1'b0; rx.in_final = 1'b0;
    check("check_busy", 64'(busy), 64'd1);
    check("resp_early", 64'(rx.resp_valid), 64'd0);
    @(posedge clk); #1;
    check("resp_valid_edge2", 64'(rx.resp_valid), 64'(fin));
    check("busy_after", 64'(busy), 64'(fin));
    check_counters("pkt");
  endtask
  task automatic handshake();
    rx.resp_ready = 1'b1;
    @(posedge clk); #1;
    rx.resp_ready = 1'b0;
    m_pkt = 0; m_first = 1;
    check("hs_valid", 64'(rx.resp_valid), 64'd0);
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_pkt", 64'(pkt_count), 64'd0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_pkt"}, 64'(pkt_count), 64'd0);
    check({tag, "_seqerr"}, 64'(seq_err_count), 64'd0);
    check({tag, "_lenerr"}, 64'(len_err_count), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rvalid"}, 64'(rx.resp_valid), 64'd0);
    check({tag, "_rseq"}, 64'(rx.resp_seq), 64'd0);
    check({tag, "_rcount"}, 64'(rx.resp_pkt_count), 64'd0);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rx.in_valid = 0; rx.in_data = 0; rx.in_last = 0; rx.in_final = 0; rx.resp_ready = 0;
    model_reset();
    #23;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd5, 1000, 0);
    send(32'd6, 1000, 0);
    send(32'd7, 1000, 1);
    check("s1_rseq", 64'(rx.resp_seq), 64'd7);
    check("s1_rcount", 64'(rx.resp_pkt_count), 64'd3);
    handshake();
    send(32'd10, 1000, 0);
    send(32'd12, 1000, 0);
    send(32'd13, 1000, 1);
    check("s2_exp_seq", 64'(dut.exp_seq), 64'd14);
    handshake();
    send(32'd20, 999, 0);
    send(32'd21, 1001, 0);
    check("s3_idle", 64'(busy), 64'd0);
    send(32'd30, 1000, 1);
    for (int i = 0; i < 20; i++) begin
      rx.in_valid = 1'b1; rx.in_data = $urandom; rx.in_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_valid", 64'(rx.resp_valid), 64'd1);
      check("hold_report", {rx.resp_seq, rx.resp_pkt_count}, {32'd30, 32'd1});
    end
    rx.in_valid = 1'b0; rx.in_last = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    check_counters("hold");
    handshake();
    send(32'hFFFF_FFFF, 1000, 0);
    send(32'd0, 1000, 0);
    check("wrap_exp_seq", 64'(dut.exp_seq), 64'd1);
    send(32'd50, 1, 0);
    for (int i = 0; i < 500; i++) begin
      rx.in_valid = 1'b1; rx.in_data = (i == 0) ? 32'd60 : $urandom; rx.in_last = 1'b0; rx.in_final = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midpkt_reset");
    rx.in_valid = 1'b0; rx.in_final = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd40, 1000, 0);
    check("after_reset_pkt", 64'(pkt_count), 64'd1);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
